// File: rtl/sevenseg_arbiter.sv
// sevenseg_arbiter: round-robin owner of a 4-digit hex display with minimum hold time
module sevenseg_arbiter #(
  parameter int NREQ = 3,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*16-1:0]   value,
  input  logic [NREQ-1:0]      blank_lz,
  output logic [NREQ-1:0]      grant,
  output logic [1:0]           owner,
  output logic                 active,
  output logic [3:0][7:0]      digits,
  output logic [3:0]           digit_en
);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [15:0][7:0] SEG = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  typedef enum logic {IDLE, SHOW} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] ptr, ptr_n, owner_n, start, idx;
  logic found, show, expired;
  logic [NREQ-1:0] grant_n;
  logic [15:0] held, held_n, live;
  logic [3:0][7:0] digits_n;
  logic [3:0] en_n;

  function automatic logic [1:0] inc(input logic [1:0] x);
    return (x == 2'(NREQ - 1)) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [1:0] wrap(input logic [2:0] x);
    return (x >= 3'(NREQ)) ? 2'(x - 3'(NREQ)) : x[1:0];
  endfunction

  // Scan downward so the earliest index after start wins; the owner itself comes last.
  always_comb begin
    start = (state == SHOW) ? inc(owner) : ptr;
    found = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[wrap({1'b0, start} + 3'(k))]) begin
        found = 1'b1;
        idx = wrap({1'b0, start} + 3'(k));
      end
  end

  // The held copy follows the owner's value while it requests, then freezes.
  assign live = req[owner] ? value[{owner, 4'b0} +: 16] : held;
  assign expired = (state == SHOW) && (cnt == LAST);

  always_comb begin
    state_n = state;
    owner_n = owner;
    grant_n = '0;
    cnt_n = (state == SHOW && cnt != LAST) ? cnt + 1'b1 : cnt;
    ptr_n = ptr;
    held_n = live;
    if (found && (state == IDLE || (expired && idx != owner))) begin
      state_n = SHOW;
      owner_n = idx;
      grant_n = NREQ'(1) << idx;
      cnt_n = '0;
      ptr_n = inc(idx);
      held_n = value[{idx, 4'b0} +: 16];
    end else if (expired && !found)
      state_n = IDLE;
    show = (state == SHOW) && (state_n == SHOW);
    en_n = !show ? 4'b0000 : !blank_lz[owner] ? 4'b1111 :
           {|live[15:12], |live[15:8], |live[15:4], 1'b1};
    digits_n = show ? {SEG[live[15:12]], SEG[live[11:8]], SEG[live[7:4]], SEG[live[3:0]]} : '1;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      grant <= '0;
      cnt <= '0;
      ptr <= '0;
      held <= '0;
      digits <= '1;
      digit_en <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      grant <= grant_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      held <= held_n;
      digits <= digits_n;
      digit_en <= en_n;
    end

  assign active = (state == SHOW);
endmodule
